// File: rtl/sm_reg_dumper_pkg.sv
// -----------------------------------------------------------------------------
// sm_reg_dumper_pkg
//   Shared constants for the register dumper and its UART transmitter:
//   ASCII codes used in the output stream, FSM state encodings, character
//   index limits, UART frame length and the nibble-to-ASCII hex encoder.
// -----------------------------------------------------------------------------
package sm_reg_dumper_pkg;

    // ASCII codes used in each dumped line
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Dumper FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    // Character positions within one line: 8 hex digits, CR, LF
    localparam logic [3:0] CR_IDX = 4'd8;
    localparam logic [3:0] LF_IDX = 4'd9;

    // UART frame: start bit, 8 data bits, stop bit
    localparam logic [3:0] UART_LAST_BIT = 4'd9;

    // Uppercase hex digit for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        logic [7:0] code;
        if (nibble < 4'd10) begin
            code = ASCII_0 + {4'd0, nibble};
        end else begin
            code = ASCII_A + {4'd0, nibble} - 8'd10;
        end
        return code;
    endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// -----------------------------------------------------------------------------
// sm_uart_tx
//   8N1 UART transmitter with a valid/ready byte input.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     data[7:0]    byte to send, sampled when valid && ready
//     valid        byte offered
//     ready        high when idle and in the last cycle of a stop bit, so
//                  consecutive bytes leave the line with no idle gap
//     tx           serial output, idle high
//   Each bit lasts exactly CLK_DIV clocks (CLK_DIV >= 2).
// -----------------------------------------------------------------------------
module sm_uart_tx
    import sm_reg_dumper_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    logic              active_q, active_d;
    logic [BAUD_W-1:0] baud_q,   baud_d;
    logic [3:0]        bit_q,    bit_d;
    logic [9:0]        shift_q,  shift_d;
    logic              bit_end;
    logic              frame_end;

    // NOTE: every signal assigned in an always_comb block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        bit_end   = (baud_q == BAUD_LAST);
        frame_end = bit_end && (bit_q == UART_LAST_BIT);
        ready     = !active_q || frame_end;

        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;

        if (valid && ready) begin
            // Frame is shifted out LSB first: start bit, data[0..7], stop bit
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = {1'b1, data, 1'b0};
        end else if (active_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (bit_q == UART_LAST_BIT) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

    // Line is forced high whenever no frame is in flight, including in reset
    assign tx = active_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/sm_reg_dumper.sv
// -----------------------------------------------------------------------------
// sm_reg_dumper
//   Walks register addresses REG_FIRST..REG_LAST of sm_cpu on a start pulse,
//   captures each value and sends it as 8 uppercase hex digits plus CR LF on
//   an 8N1 UART line.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     start        one-cycle dump request, ignored while busy
//     busy         high from the accepting edge until the dump finishes
//     done         one-cycle pulse after the last stop bit
//     regAddr      register address to sm_cpu (holds between dumps)
//     regData      register value from sm_cpu, combinational from regAddr
//     tx           UART serial output, idle high
// -----------------------------------------------------------------------------
module sm_reg_dumper
    import sm_reg_dumper_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int REG_FIRST = 0,
    parameter int REG_LAST  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx
);

    localparam logic [4:0] ADDR_FIRST = 5'(REG_FIRST);
    localparam logic [4:0] ADDR_LAST  = 5'(REG_LAST);

    logic [1:0]  state_q,    state_d;
    logic [4:0]  addr_q,     addr_d;
    logic [31:0] hold_q,     hold_d;
    logic [3:0]  char_idx_q, char_idx_d;
    logic        done_q,     done_d;

    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [3:0]  nibble;

    // Character select: digits are sent most significant nibble first
    always_comb begin
        nibble = hold_q[5'd28 - {char_idx_q[2:0], 2'b00} +: 4];
        case (char_idx_q)
            CR_IDX:  tx_data = ASCII_CR;
            LF_IDX:  tx_data = ASCII_LF;
            default: tx_data = hex_ascii(nibble);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hold_d     = hold_q;
        char_idx_d = char_idx_q;
        done_d     = 1'b0;
        tx_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ADDR;
                    addr_d  = ADDR_FIRST;
                end
            end
            ST_ADDR: begin
                hold_d     = regData;
                char_idx_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    if (char_idx_q == LF_IDX) begin
                        // The next address cycle overlaps the LF on the line,
                        // so its first digit is ready when the LF finishes.
                        if (addr_q == ADDR_LAST) begin
                            state_d = ST_FIN;
                        end else begin
                            addr_d  = addr_q + 5'd1;
                            state_d = ST_ADDR;
                        end
                    end else begin
                        char_idx_d = char_idx_q + 4'd1;
                    end
                end
            end
            ST_FIN: begin
                // With nothing offered, ready rises in the last stop-bit cycle
                if (tx_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            hold_q     <= '0;
            char_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            char_idx_q <= char_idx_d;
            done_q     <= done_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign regAddr = addr_q;

    sm_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (tx_data),
        .valid (tx_valid),
        .ready (tx_ready),
        .tx    (tx)
    );

endmodule

// File: tb/tb_sm_reg_dumper.sv
// -----------------------------------------------------------------------------
// tb_sm_reg_dumper
//   Two dumper instances: "a" sweeps 0..31 with CLK_DIV=2, "b" dumps register
//   2 only with CLK_DIV=4. Expected bytes and addresses are queued when a dump
//   is requested; independent monitors decode the UART lines and the address
//   bus and compare against those queues.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sm_reg_dumper;

    localparam int DIV_A = 2;
    localparam int DIV_B = 4;
    localparam int B_REG = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start_a, start_b;
    logic        busy_a, busy_b, done_a, done_b, tx_a, tx_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [31:0] reg_a [32];
    logic [31:0] val_b;

    // Register file models: combinational read like sm_cpu
    assign data_a = reg_a[addr_a];
    assign data_b = (addr_b == 5'(B_REG)) ? val_b : 32'hBAD0_BAD0;

    sm_reg_dumper #(.CLK_DIV(DIV_A), .REG_FIRST(0), .REG_LAST(31)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .regAddr(addr_a), .regData(data_a), .tx(tx_a)
    );

    sm_reg_dumper #(.CLK_DIV(DIV_B), .REG_FIRST(B_REG), .REG_LAST(B_REG)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .regAddr(addr_b), .regData(data_b), .tx(tx_b)
    );

    // ---------------------------------------------------------------- scoreboard
    byte unsigned exp_a[$];
    byte unsigned exp_b[$];
    logic [4:0]   addr_exp_a[$];
    int n_checks   = 0;
    int n_fail     = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int exp_done_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
    endtask

    function automatic logic tx_of(input int k);
        return (k == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic rst_of(input int k);
        return (k == 0) ? rst_a : rst_b;
    endfunction

    function automatic logic done_of(input int k);
        return (k == 0) ? done_a : done_b;
    endfunction

    function automatic int exp_size(input int k);
        return (k == 0) ? exp_a.size() : exp_b.size();
    endfunction

    function automatic byte unsigned exp_pop(input int k);
        return (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
    endfunction

    function automatic void push_byte(input int k, input byte unsigned b);
        if (k == 0) exp_a.push_back(b);
        else        exp_b.push_back(b);
    endfunction

    // Reference model: one line is the value in uppercase hex, then CR LF
    function automatic void push_line(input int k, input logic [31:0] v);
        string hexd = "0123456789ABCDEF";
        for (int n = 7; n >= 0; n--) begin
            push_byte(k, hexd[int'((v >> (4 * n)) & 32'hF)]);
        end
        push_byte(k, 8'h0D);
        push_byte(k, 8'h0A);
    endfunction

    function automatic void push_dump_a();
        for (int a = 0; a < 32; a++) begin
            push_line(0, reg_a[a]);
            addr_exp_a.push_back(5'(a));
        end
        exp_done_a++;
    endfunction

    // ---------------------------------------------------------------- monitors
    // UART decoder: samples 1 ns after each edge, checks every cycle of every
    // bit, and requires the next start bit immediately after a stop bit while
    // further bytes are still expected.
    task automatic uart_mon(input int k, input int div);
        logic [9:0]   bits;
        logic         glitch;
        logic         aborted;
        logic         have_start;
        byte unsigned e;
        string        pfx;
        pfx = (k == 0) ? "a_" : "b_";
        have_start = 1'b0;
        forever begin
            if (!have_start) begin
                @(posedge clk); #1;
                if (rst_of(k) || tx_of(k)) continue;
            end
            have_start = 1'b0;
            glitch     = 1'b0;
            aborted    = 1'b0;
            bits       = '0;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < div; c++) begin
                    if (!aborted) begin
                        if (b != 0 || c != 0) begin
                            @(posedge clk); #1;
                        end
                        if (rst_of(k))              aborted = 1'b1;
                        else if (c == 0)            bits[b] = tx_of(k);
                        else if (tx_of(k) !== bits[b]) glitch = 1'b1;
                    end
                end
            end
            if (aborted) continue;
            check({pfx, "bit_width"}, 32'(glitch), 32'd0);
            check({pfx, "stop_bit"}, 32'(bits[9]), 32'd1);
            if (exp_size(k) == 0) begin
                fail_unexpected({pfx, "extra_byte"}, 32'(bits[8:1]));
            end else begin
                e = exp_pop(k);
                check({pfx, "byte"}, 32'(bits[8:1]), 32'(e));
            end
            if (exp_size(k) != 0) begin
                @(posedge clk); #1;
                if (!rst_of(k)) begin
                    check({pfx, "back_to_back"}, 32'(tx_of(k)), 32'd0);
                    have_start = !tx_of(k);
                end
            end
        end
    endtask

    initial uart_mon(0, DIV_A);
    initial uart_mon(1, DIV_B);

    // Address sequence of instance a: one entry per new address while busy
    initial begin : addr_mon
        logic       prev_busy;
        logic [4:0] prev_addr;
        logic [4:0] e;
        prev_busy = 1'b0;
        prev_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_a) begin
                prev_busy = 1'b0;
            end else begin
                if (busy_a && (!prev_busy || addr_a != prev_addr)) begin
                    if (addr_exp_a.size() == 0) begin
                        fail_unexpected("a_extra_addr", 32'(addr_a));
                    end else begin
                        e = addr_exp_a.pop_front();
                        check("a_addr_seq", 32'(addr_a), 32'(e));
                    end
                end
                prev_busy = busy_a;
                prev_addr = addr_a;
            end
        end
    end

    initial begin : done_mon
        forever begin
            @(posedge clk); #1;
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------------------------------------------------------- stimulus
    // Returns 1 ns after the edge that raises done (or after the budget).
    task automatic wait_done(input int k, input int budget);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk); #1;
            seen = done_of(k);
        end
        check((k == 0) ? "a_done_in_budget" : "b_done_in_budget", 32'(seen), 32'd1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_bytes_left"}, 32'(exp_a.size()), 32'd0);
        check({tag, "_addrs_left"}, 32'(addr_exp_a.size()), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt_a), 32'(exp_done_a));
    endtask

    task automatic run_dump_a(input string tag);
        push_dump_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        wait_done(0, 7000);
        @(negedge clk);
        check_drained(tag);
    endtask

    // Start a dump, assert reset `edges` clocks after the accepting edge
    task automatic reset_mid(input int edges, input logic [4:0] addr_before);
        for (int i = 0; i < 32; i++) reg_a[i] = $urandom();
        push_dump_a();
        exp_done_a--;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #2; start_a = 1'b0;
        repeat (edges) @(posedge clk);
        #2;
        check("a_addr_before_rst", 32'(addr_a), 32'(addr_before));
        rst_a = 1'b1;
        #1;
        check("a_rst_tx", 32'(tx_a), 32'd1);
        check("a_rst_busy", 32'(busy_a), 32'd0);
        check("a_rst_addr", 32'(addr_a), 32'd0);
        check("a_rst_done", 32'(done_a), 32'd0);
        exp_a.delete();
        addr_exp_a.delete();
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        logic busy_ok;
        logic early_done;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        val_b = 32'h1234_ABCD;
        for (int i = 0; i < 32; i++) reg_a[i] = '0;
        #2;
        check("a_reset_tx", 32'(tx_a), 32'd1);
        check("a_reset_busy", 32'(busy_a), 32'd0);
        check("a_reset_done", 32'(done_a), 32'd0);
        check("a_reset_addr", 32'(addr_a), 32'd0);
        check("b_reset_tx", 32'(tx_b), 32'd1);
        check("b_reset_busy", 32'(busy_b), 32'd0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // Single register, exact timing against E0
        push_line(1, val_b);
        start_b = 1'b1;
        @(posedge clk); #1;
        check("b_busy_e0", 32'(busy_b), 32'd1);
        check("b_addr_e0", 32'(addr_b), 32'(B_REG));
        @(negedge clk); start_b = 1'b0;
        busy_ok    = 1'b1;
        early_done = 1'b0;
        for (int n = 1; n <= 403; n++) begin
            @(posedge clk); #1;
            if (n == 1) check("b_tx_e1", 32'(tx_b), 32'd1);
            if (n == 2) check("b_tx_e2", 32'(tx_b), 32'd0);
            if (n < 402) begin
                if (!busy_b) busy_ok = 1'b0;
                if (done_b)  early_done = 1'b1;
            end
            if (n == 402) begin
                check("b_done_e402", 32'(done_b), 32'd1);
                check("b_busy_e402", 32'(busy_b), 32'd0);
            end
            if (n == 403) check("b_done_e403", 32'(done_b), 32'd0);
        end
        check("b_busy_span", 32'(busy_ok), 32'd1);
        check("b_no_early_done", 32'(early_done), 32'd0);
        check("b_bytes_left", 32'(exp_b.size()), 32'd0);
        check("b_done_count", 32'(done_cnt_b), 32'd1);

        // Full sweep with a start pulse landing mid line 0
        for (int i = 0; i < 32; i++) reg_a[i] = 32'(i) * 32'h0101_0101;
        push_dump_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (25) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        wait_done(0, 7000);

        // Restart on the edge right after done: same values, same bytes
        @(negedge clk);
        check_drained("a_sweep");
        push_dump_a();
        start_a = 1'b1;
        @(posedge clk); #1;
        check("a_restart_busy", 32'(busy_a), 32'd1);
        check("a_restart_addr", 32'(addr_a), 32'd0);
        @(negedge clk); start_a = 1'b0;
        wait_done(0, 7000);
        @(negedge clk);
        check_drained("a_restart");

        // Extreme digit values, back-to-back across line boundaries
        for (int i = 0; i < 32; i++) reg_a[i] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
        run_dump_a("a_b2b");
        repeat (5) @(negedge clk);
        check("a_addr_hold", 32'(addr_a), 32'd31);

        // Reset during data bit 3 of the 2nd character, and deep in line 7
        reset_mid(30, 5'd0);
        reset_mid(1432, 5'd7);

        // Clean random dump after reset
        for (int i = 0; i < 32; i++) reg_a[i] = $urandom();
        run_dump_a("a_random");

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
